// File: rtl/regfile.sv
// regfile: 16-entry x 32-bit register file, one synchronous write port and
// two registered read ports feeding the ALU operand buses.
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-low reset; clears storage and outputs
//   en       global enable; when low, memory and outputs hold
//   wt       write strobe (qualified by en): mem[si] <= ip
//   rd       read strobe (qualified by en): op1 <= mem[so1], op2 <= mem[so2]
//   si       write address
//   so1/so2  read addresses, ports 1 and 2
//   ip       write data
//   op1/op2  registered read data
//
// Optional feature macro: REGFILE_WR_BYPASS_EN
//   undefined: a same-edge read of the address being written returns the
//              old stored value.
//   defined:   that read port returns the new write data instead.
module regfile #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              wt,
   input  logic              rd,
   input  logic [ADDR_W-1:0] si,
   input  logic [ADDR_W-1:0] so1,
   input  logic [ADDR_W-1:0] so2,
   input  logic [DATA_W-1:0] ip,
   output logic [DATA_W-1:0] op1,
   output logic [DATA_W-1:0] op2
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [DATA_W-1:0] op1_q, op1_d;
   logic [DATA_W-1:0] op2_q, op2_d;

   logic wr_en;
   logic rd_en;

   assign wr_en = en & wt;
   assign rd_en = en & rd;

   always_comb begin
      mem_d = mem_q;
      op1_d = op1_q;
      op2_d = op2_q;

      if (wr_en) begin
         mem_d[si] = ip;
      end

      // Reads sample mem_q, so a same-edge write is not visible here.
      if (rd_en) begin
         op1_d = mem_q[so1];
         op2_d = mem_q[so2];
`ifdef REGFILE_WR_BYPASS_EN
         if (wt && (so1 == si)) begin
            op1_d = ip;
         end
         if (wt && (so2 == si)) begin
            op2_d = ip;
         end
`endif
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_q <= '{default: '0};
         op1_q <= '0;
         op2_q <= '0;
      end else begin
         mem_q <= mem_d;
         op1_q <= op1_d;
         op2_q <= op2_d;
      end
   end

   assign op1 = op1_q;
   assign op2 = op2_q;

endmodule

// File: tb/tb_regfile.sv
module tb_regfile;

`ifdef REGFILE_WR_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic        en, wt, rd;
   logic [3:0]  si, so1, so2;
   logic [31:0] ip;
   logic [31:0] op1, op2;

   int passed;
   int total;

   // Reference model: plain storage array plus expected outputs.
   logic [31:0] m [16];
   logic [31:0] e1, e2;

   typedef struct {
      logic        v_en, v_wt, v_rd;
      logic [3:0]  v_si, v_so1, v_so2;
      logic [31:0] v_ip, x1, x2;
   } vec_t;

   vec_t tbl [12];

   regfile #(.DATA_W(32), .ADDR_W(4)) dut (
      .clk(clk), .rst(rst), .en(en), .wt(wt), .rd(rd),
      .si(si), .so1(so1), .so2(so2), .ip(ip),
      .op1(op1), .op2(op2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic model_clear();
      for (int i = 0; i < 16; i++) m[i] = '0;
      e1 = '0;
      e2 = '0;
   endtask

   // Drive one cycle of inputs, let the edge happen, update the model from the
   // behavioural rules (read sees pre-write contents unless bypass), return at
   // the following negedge so outputs can be sampled.
   task automatic step(input logic a_en, input logic a_wt, input logic a_rd,
                       input logic [3:0] a_si, input logic [3:0] a_so1,
                       input logic [3:0] a_so2, input logic [31:0] a_ip);
      en = a_en; wt = a_wt; rd = a_rd;
      si = a_si; so1 = a_so1; so2 = a_so2; ip = a_ip;
      @(posedge clk);
      if (a_en && a_rd) begin
         e1 = (BYP && a_wt && a_so1 == a_si) ? a_ip : m[a_so1];
         e2 = (BYP && a_wt && a_so2 == a_si) ? a_ip : m[a_so2];
      end
      if (a_en && a_wt) m[a_si] = a_ip;
      @(negedge clk);
   endtask

   initial begin
      passed = 0;
      total  = 0;
      model_clear();

      // Directed sequence; expected outputs written out by hand.
      tbl[0]  = '{1, 1, 0, 4'd0,  4'd0,  4'd0,  32'h11111111, 32'h0, 32'h0};
      tbl[1]  = '{1, 1, 0, 4'd1,  4'd0,  4'd0,  32'h22222222, 32'h0, 32'h0};
      tbl[2]  = '{1, 0, 1, 4'd0,  4'd0,  4'd1,  32'h0, 32'h11111111, 32'h22222222};
      tbl[3]  = '{0, 1, 1, 4'd2,  4'd2,  4'd2,  32'hDEADBEEF, 32'h11111111, 32'h22222222};
      tbl[4]  = '{1, 0, 1, 4'd0,  4'd2,  4'd0,  32'h0, 32'h0, 32'h11111111};
      tbl[5]  = '{1, 0, 0, 4'd0,  4'd1,  4'd1,  32'h0, 32'h0, 32'h11111111};
      tbl[6]  = '{1, 1, 0, 4'd3,  4'd0,  4'd0,  32'hAAAAAAAA, 32'h0, 32'h11111111};
      tbl[7]  = '{1, 1, 1, 4'd3,  4'd3,  4'd3,  32'h55555555,
                  BYP ? 32'h55555555 : 32'hAAAAAAAA, BYP ? 32'h55555555 : 32'hAAAAAAAA};
      tbl[8]  = '{1, 0, 1, 4'd0,  4'd3,  4'd0,  32'h0, 32'h55555555, 32'h11111111};
      tbl[9]  = '{1, 0, 1, 4'd0,  4'd1,  4'd1,  32'h0, 32'h22222222, 32'h22222222};
      tbl[10] = '{1, 1, 1, 4'd15, 4'd15, 4'd14, 32'hCAFEF00D,
                  BYP ? 32'hCAFEF00D : 32'h0, 32'h0};
      tbl[11] = '{1, 0, 1, 4'd0,  4'd15, 4'd3,  32'h0, 32'hCAFEF00D, 32'h55555555};

      // Reset held with every control asserted: outputs stay 0.
      rst = 1'b0;
      en = 1'b1; wt = 1'b1; rd = 1'b1;
      si = 4'd5; so1 = 4'd5; so2 = 4'd6; ip = 32'hFFFFFFFF;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk($sformatf("reset_hold%0d_op1", i), op1, 32'h0);
         chk($sformatf("reset_hold%0d_op2", i), op2, 32'h0);
      end
      rst = 1'b1;

      // Every entry reads back 0 after reset.
      for (int i = 0; i < 16; i++) begin
         step(1, 0, 1, 4'd0, i[3:0], 4'(15 - i), 32'h0);
         chk($sformatf("post_reset_rd%0d_op1", i), op1, 32'h0);
         chk($sformatf("post_reset_rd%0d_op2", i), op2, 32'h0);
      end

      for (int i = 0; i < 12; i++) begin
         step(tbl[i].v_en, tbl[i].v_wt, tbl[i].v_rd, tbl[i].v_si,
              tbl[i].v_so1, tbl[i].v_so2, tbl[i].v_ip);
         chk($sformatf("vec%0d_op1", i), op1, tbl[i].x1);
         chk($sformatf("vec%0d_op2", i), op2, tbl[i].x2);
      end

      // Asynchronous reset between edges: outputs clear before next posedge.
      #2 rst = 1'b0;
      #1;
      chk("async_rst_op1", op1, 32'h0);
      chk("async_rst_op2", op2, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      model_clear();
      step(1, 0, 1, 4'd0, 4'd0, 4'd1, 32'h0);
      chk("after_async_rd0", op1, 32'h0);
      chk("after_async_rd1", op2, 32'h0);
      step(1, 0, 1, 4'd0, 4'd3, 4'd15, 32'h0);
      chk("after_async_rd3", op1, 32'h0);
      chk("after_async_rd15", op2, 32'h0);

      // Randomized traffic against the reference model.
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 7) != 0), $urandom_range(0, 1) == 1,
              $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)),
              4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), $urandom);
         chk($sformatf("rand%0d_op1", i), op1, e1);
         chk($sformatf("rand%0d_op2", i), op2, e2);
      end

      // Final sweep of storage contents against the model.
      for (int i = 0; i < 16; i += 2) begin
         step(1, 0, 1, 4'd0, i[3:0], 4'(i + 1), 32'h0);
         chk($sformatf("sweep%0d", i), op1, m[i]);
         chk($sformatf("sweep%0d", i + 1), op2, m[i + 1]);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
